rr_mux_arbiter: RTL and testbench

- Sequential front-end for the 2:1 data mux: arbitrates between two valid/ready source streams (A, B) with round-robin fairness, drives the mux select, and captures the selected word in a single-entry output register.
- Sits directly upstream of the datapath consumer. Its `sel` output is the select line of the 2:1 mux (0 = A, 1 = B).
- Keeps saturating per-source grant counters for debug and coverage.

---
 rtl/rr_mux_arbiter.sv | 88 ++++++++
 tb/tb_rr_mux_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin front-end for the 2:1 data mux: arbitrates two valid/ready
// sources, captures the winner in a one-entry output register, counts grants.
module rr_mux_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] out_data_q;
    logic             sel_q;
    logic             last_grant_q;
    logic [CNT_W-1:0] cnt_a_q;
    logic [CNT_W-1:0] cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q;
    logic [CNT_W-1:0] cnt_b_d;
    logic             load_en;
    logic             grant_a;
    logic             grant_b;
    logic             grant_any;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    // On a tie the source that did not win last time gets the grant; reset
    // blocks every handshake so nothing is accepted while rst is high.
    always_comb begin
        load_en   = (state_q == EMPTY) || out_ready;
        grant_a   = !rst && load_en && a_valid && (!b_valid || last_grant_q);
        grant_b   = !rst && load_en && b_valid && (!a_valid || !last_grant_q);
        grant_any = grant_a || grant_b;
        cnt_a_d   = grant_a ? sat_inc(cnt_a_q) : cnt_a_q;
        cnt_b_d   = grant_b ? sat_inc(cnt_b_q) : cnt_b_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            out_data_q   <= '0;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_a_q      <= '0;
            cnt_b_q      <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            case (state_q)
                EMPTY:   if (grant_any) state_q <= FULL;
                FULL:    if (out_ready && !grant_any) state_q <= EMPTY;
                default: state_q <= EMPTY;
            endcase
            if (grant_any) begin
                out_data_q   <= grant_b ? b_data : a_data;
                sel_q        <= grant_b;
                last_grant_q <= grant_b;
            end
        end
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign sel       = sel_q;
    assign cnt_a     = cnt_a_q;
    assign cnt_b     = cnt_b_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: a driver predicts grants from a
// behavioural model and queues expected words; a monitor checks deliveries.
module tb_rr_mux_arbiter;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             a_valid = 1'b0;
    logic [WIDTH-1:0] a_data = '0;
    logic             a_ready;
    logic             b_valid = 1'b0;
    logic [WIDTH-1:0] b_data = '0;
    logic             b_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;
    logic             sel;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    rr_mux_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .sel(sel), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    always #5 clk = ~clk;

    // Reference model state: a queue of {sel, data} words in flight plus
    // plain integers for occupancy, last winner and grant counts.
    logic [WIDTH:0] exp_q[$];
    bit m_full = 0;
    int m_last = 1;
    int m_cnt_a = 0;
    int m_cnt_b = 0;
    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic cycle(input bit r, input bit av, input logic [WIDTH-1:0] ad,
                         input bit bv, input logic [WIDTH-1:0] bd, input bit ordy);
        bit le, ga, gb;
        @(negedge clk);
        rst = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
        #1;
        chk("out_valid", out_valid, m_full);
        chk("cnt_a", cnt_a, m_cnt_a);
        chk("cnt_b", cnt_b, m_cnt_b);
        le = !m_full || ordy;
        ga = !r && le && av && (!bv || m_last == 1);
        gb = !r && le && bv && (!av || m_last == 0);
        chk("a_ready", a_ready, ga);
        chk("b_ready", b_ready, gb);
        if (r) begin
            m_full = 0; m_last = 1; m_cnt_a = 0; m_cnt_b = 0;
            exp_q.delete();
        end else if (ga) begin
            exp_q.push_back({1'b0, ad});
            m_full = 1; m_last = 0;
            m_cnt_a = (m_cnt_a < CMAX) ? m_cnt_a + 1 : m_cnt_a;
        end else if (gb) begin
            exp_q.push_back({1'b1, bd});
            m_full = 1; m_last = 1;
            m_cnt_b = (m_cnt_b < CMAX) ? m_cnt_b + 1 : m_cnt_b;
        end else if (ordy) begin
            m_full = 0;
        end
    endtask

    // Monitor: every word the consumer takes must be the oldest expected one.
    initial begin
        logic [WIDTH:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e[WIDTH-1:0]);
                    chk("sel", sel, e[WIDTH]);
                end
            end
        end
    end

    initial begin
        @(posedge clk);

        // Reset with both sources pending: nothing accepted.
        cycle(1, 1, 8'hAA, 1, 8'hBB, 1);
        cycle(1, 1, 8'hAA, 1, 8'hBB, 1);
        cycle(0, 0, 8'h00, 0, 8'h00, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sel", sel, 0);
        chk("rst_cnt_a", cnt_a, 0);
        chk("rst_cnt_b", cnt_b, 0);

        // Tie-break and alternation.
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 8'h11, 1, 8'h22, 1);
            chk("alt_a_ready", a_ready, (i % 2 == 0));
        end
        cycle(0, 0, 8'h00, 0, 8'h00, 1);
        chk("alt_cnt_a", cnt_a, 2);
        chk("alt_cnt_b", cnt_b, 2);
        chk("alt_last_data", out_data, 8'h22);

        // Backpressure: 0x11 held while both sources wait.
        cycle(0, 1, 8'h11, 0, 8'h00, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 8'h11, 1, 8'h22, 0);
            chk("bp_hold_data", out_data, 8'h11);
        end
        cycle(0, 1, 8'h11, 1, 8'h22, 1);
        chk("bp_b_ready", b_ready, 1);
        cycle(0, 0, 8'h00, 0, 8'h00, 1);
        chk("bp_next_data", out_data, 8'h22);
        chk("bp_next_sel", sel, 1);

        // Single source B.
        cycle(1, 0, 8'h00, 0, 8'h00, 1);
        cycle(0, 0, 8'h00, 1, 8'h05, 1);
        cycle(0, 0, 8'h00, 1, 8'h06, 1);
        cycle(0, 0, 8'h00, 1, 8'h07, 1);
        cycle(0, 0, 8'h00, 0, 8'h00, 1);
        chk("single_cnt_b", cnt_b, 3);
        chk("single_cnt_a", cnt_a, 0);

        // Drain to empty.
        cycle(0, 1, 8'h11, 0, 8'h00, 1);
        cycle(0, 0, 8'h00, 0, 8'h00, 1);
        chk("drain_full", out_valid, 1);
        cycle(0, 0, 8'h00, 0, 8'h00, 1);
        chk("drain_empty", out_valid, 0);
        chk("drain_data_hold", out_data, 8'h11);

        // Saturation, then reset while FULL.
        cycle(1, 0, 8'h00, 0, 8'h00, 1);
        for (int i = 0; i < 5; i++) cycle(0, 1, 8'(8'h30 + i), 0, 8'h00, 1);
        cycle(0, 0, 8'h00, 0, 8'h00, 1);
        chk("sat_cnt_a", cnt_a, 3);
        cycle(0, 1, 8'h3F, 0, 8'h00, 1);
        cycle(1, 1, 8'h40, 1, 8'h41, 0);
        cycle(0, 1, 8'h33, 1, 8'h44, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_cnt_a", cnt_a, 0);
        chk("midrst_first_tie", a_ready, 1);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(63) == 0), 1'($urandom), 8'($urandom),
                  1'($urandom), 8'($urandom), ($urandom_range(3) != 0));
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 0, 8'h00, 1);
        chk("final_queue_empty", exp_q.size(), 0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
